cpu_mem_resp: RTL

Memory-side responder for the CPU bus. It terminates CPU read/write strobes. The 2 KB internal work RAM is served with zero wait states. All other addresses are forwarded to a back-end port (PPU/APU/cartridge) with an ack handshake, and wait states are inserted via rdy. It sits between the CPU core and the system bus fabric, on the responder side of the CPU interface.

---
 rtl/cpu_mem_resp.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cpu_mem_resp.sv
// cpu_mem_resp: CPU-bus responder, 2 KB zero-wait work RAM plus a back-end port.
// Optional macro MEM_RESP_RESET_VEC_EN serves 0xFFFC/0xFFFD reads from RESET_VECTOR.
module cpu_mem_resp #(
    parameter int          RAM_AW       = 11,
    parameter int          TIMEOUT      = 64,
    parameter logic [15:0] RESET_VECTOR = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic        wen,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic        ext_req,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    input  logic        ext_ack,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [7:0]          ram [0:(1<<RAM_AW)-1];

    logic                accept;
    logic                in_ram;
    logic                vec_hit;
    logic                ram_wr;
    logic                ram_rd;
    logic                ext_go;
    logic [RAM_AW-1:0]   ram_idx;
    logic [7:0]          vec_data;

    assign ram_idx  = cpu_addr_out[RAM_AW-1:0];
    assign in_ram   = (cpu_addr_out[15:13] == 3'b000);
    assign vec_data = cpu_addr_out[0] ? RESET_VECTOR[15:8]
                                      : RESET_VECTOR[7:0];

`ifdef MEM_RESP_RESET_VEC_EN
    assign vec_hit = ren && !wen && (cpu_addr_out[15:1] == 15'h7FFE);
`else
    assign vec_hit = 1'b0;
`endif

    // DONE decodes like IDLE; a simultaneous ren+wen is handled as a write
    assign accept = (state != REQ) && (ren || wen);
    assign ram_wr = accept && wen && in_ram;
    assign ram_rd = accept && !wen && in_ram;
    assign ext_go = accept && !in_ram && !vec_hit;

    // Work RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && ram_wr) begin
            ram[ram_idx] <= cpu_data_out;
        end
    end

    // Access sequencer: zero-wait RAM reads, back-end handshake with timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rdy         <= 1'b1;
            cpu_data_in <= 8'h00;
            ext_req     <= 1'b0;
            ext_we      <= 1'b0;
            ext_addr    <= 16'h0000;
            ext_wdata   <= 8'h00;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    if (ren && wen) begin
                        err <= 1'b1;
                    end
                    if (accept && vec_hit) begin
                        cpu_data_in <= vec_data;
                    end else if (ram_rd) begin
                        cpu_data_in <= ram[ram_idx];
                    end else if (ext_go) begin
                        state     <= REQ;
                        rdy       <= 1'b0;
                        cnt       <= '0;
                        ext_req   <= 1'b1;
                        ext_we    <= wen;
                        ext_addr  <= cpu_addr_out;
                        ext_wdata <= cpu_data_out;
                    end
                end
                REQ: begin
                    if (ext_ack) begin
                        if (!ext_we) begin
                            cpu_data_in <= ext_rdata;
                        end
                        ext_req <= 1'b0;
                        rdy     <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // no answer: release the CPU, leave open-bus data
                        ext_req <= 1'b0;
                        err     <= 1'b1;
                        rdy     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rdy     <= 1'b1;
                    ext_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
